// File: rtl/fir_coeff_pkg.sv
// Shared sizing, FSM encoding and error-flag indices for the double-buffered
// FIR coefficient bank.
package fir_coeff_pkg;

    localparam int NLANES = 4;
    localparam int NADDR  = 4;
    localparam int CW     = 8;
    localparam int WW     = 16;
    localparam int AW     = 2;
    localparam int ERR_W  = 8;

    // Shadow-load / swap controller encoding
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOADING = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    // Sticky out_err bit positions; bits above ERR_PEND read as zero
    localparam int ERR_RANGE = 0;
    localparam int ERR_DUP   = 1;
    localparam int ERR_PEND  = 2;

endpackage

// File: rtl/fir_coeff_bank_if.sv
// Bus bundle between a coefficient host and fir_coeff_bank (clock and reset
// stay as plain ports of the bank).
interface fir_coeff_bank_if #(
    parameter int NLANES = fir_coeff_pkg::NLANES,
    parameter int NADDR  = fir_coeff_pkg::NADDR,
    parameter int CW     = fir_coeff_pkg::CW
) ();
    localparam int WW = fir_coeff_pkg::WW;
    localparam int AW = fir_coeff_pkg::AW;

    // Strobes are sampled on the rising clock edge and act for exactly the
    // cycles they are high; the bank never back-pressures (always ready).
    // coeff_out_valid qualifies coeff_out_data two cycles after coeff_read.
    logic                      coeff_areset;
    logic [NLANES-1:0]         coeff_we;
    logic [AW-1:0]             coeff_adr;
    logic [NLANES*WW-1:0]      coeff_in_data;
    logic                      coeff_read;
    logic [NLANES-1:0]         coeff_out_valid;
    logic [NLANES*WW-1:0]      coeff_out_data;
    logic                      swap_ok;
    logic [NLANES*NADDR*CW-1:0] coeff_active;
    logic                      coeff_update;
    logic                      loaded;
    logic [7:0]                out_err;

    modport master (
        output coeff_areset, coeff_we, coeff_adr, coeff_in_data, coeff_read, swap_ok,
        input  coeff_out_valid, coeff_out_data, coeff_active, coeff_update, loaded, out_err
    );

    modport slave (
        input  coeff_areset, coeff_we, coeff_adr, coeff_in_data, coeff_read, swap_ok,
        output coeff_out_valid, coeff_out_data, coeff_active, coeff_update, loaded, out_err
    );

endinterface

// File: rtl/fir_coeff_lane.sv
// One coefficient lane: shadow and active word arrays, per-word written
// flags and a two-stage registered read path off the shadow array.
module fir_coeff_lane #(
    parameter int NADDR = fir_coeff_pkg::NADDR,
    parameter int CW    = fir_coeff_pkg::CW,
    parameter int WW    = fir_coeff_pkg::WW,
    parameter int AW    = fir_coeff_pkg::AW
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                areset_i,
    input  logic                we_i,
    input  logic [AW-1:0]       adr_i,
    input  logic [WW-1:0]       wdata_i,
    input  logic                read_i,
    input  logic                commit_i,
    output logic                rd_valid_o,
    output logic [WW-1:0]       rd_data_o,
    output logic [NADDR*CW-1:0] active_o,
    output logic                full_d_o,
    output logic                range_err_o,
    output logic                dup_err_o
);

    logic [NADDR-1:0][CW-1:0] shadow_q, shadow_d;
    logic [NADDR-1:0][CW-1:0] active_q, active_d;
    logic [NADDR-1:0]         written_q, written_d;
    logic                     s1_valid_q;
    logic [CW-1:0]            s1_data_q;
    logic                     rd_valid_q;
    logic [WW-1:0]            rd_data_q;

    // Clear wins over a same-cycle write; commit copies the pre-edge shadow.
    always_comb begin
        shadow_d  = shadow_q;
        written_d = written_q;
        active_d  = active_q;
        if (areset_i) begin
            shadow_d  = '0;
            written_d = '0;
        end else if (we_i) begin
            shadow_d[adr_i]  = wdata_i[CW-1:0];
            written_d[adr_i] = 1'b1;
        end
        if (commit_i) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q   <= '0;
            active_q   <= '0;
            written_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            written_q  <= written_d;
            // Sampling shadow_q (not shadow_d) gives read-before-write and
            // lets reads in flight survive a coefficient clear.
            s1_valid_q <= read_i;
            s1_data_q  <= read_i ? shadow_q[adr_i] : '0;
            rd_valid_q <= s1_valid_q;
            rd_data_q  <= s1_valid_q ? {{(WW-CW){s1_data_q[CW-1]}}, s1_data_q} : '0;
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign active_o    = active_q;
    assign full_d_o    = &written_d;
    assign range_err_o = we_i & (wdata_i[WW-1:CW] != {(WW-CW){wdata_i[CW-1]}});
    assign dup_err_o   = we_i & written_q[adr_i];

endmodule

// File: rtl/fir_coeff_bank.sv
// Double-buffered FIR coefficient store: hosts load a shadow bank lane by
// lane, and the complete set is swapped into the live bank at a safe point.
module fir_coeff_bank #(
    parameter int NLANES = fir_coeff_pkg::NLANES,
    parameter int NADDR  = fir_coeff_pkg::NADDR,
    parameter int CW     = fir_coeff_pkg::CW
) (
    input  logic            clk,
    input  logic            reset_n,
    fir_coeff_bank_if.slave bus,
    output logic [1:0]      dbg_state_o
);
    import fir_coeff_pkg::*;

    localparam int LW = NADDR * CW;

    logic [1:0]           state_q, state_d;
    logic [2:0]           err_q, err_d;
    logic [NLANES-1:0]    lane_full, lane_range_err, lane_dup_err, rd_valid;
    logic [NLANES*WW-1:0] rd_data;
    logic [NLANES*LW-1:0] active;
    logic                 any_we, all_full, commit;

    assign any_we   = |bus.coeff_we;
    assign all_full = &lane_full;
    // A write in PENDING reopens loading, so it also blocks the swap.
    assign commit   = (state_q == ST_PENDING) && !any_we && bus.swap_ok && !bus.coeff_areset;

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        fir_coeff_lane #(
            .NADDR (NADDR),
            .CW    (CW),
            .WW    (WW),
            .AW    (AW)
        ) u_lane (
            .clk_i       (clk),
            .rst_ni      (reset_n),
            .areset_i    (bus.coeff_areset),
            .we_i        (bus.coeff_we[k]),
            .adr_i       (bus.coeff_adr),
            .wdata_i     (bus.coeff_in_data[WW*k +: WW]),
            .read_i      (bus.coeff_read),
            .commit_i    (commit),
            .rd_valid_o  (rd_valid[k]),
            .rd_data_o   (rd_data[WW*k +: WW]),
            .active_o    (active[LW*k +: LW]),
            .full_d_o    (lane_full[k]),
            .range_err_o (lane_range_err[k]),
            .dup_err_o   (lane_dup_err[k])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_we) state_d = ST_LOADING;
            ST_LOADING: if (all_full) state_d = ST_PENDING;
            ST_PENDING: begin
                if (any_we) begin
                    state_d = ST_LOADING;
                end else if (bus.swap_ok) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (bus.coeff_areset) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        err_d = err_q;
        if (|lane_range_err) err_d[ERR_RANGE] = 1'b1;
        if (|lane_dup_err) err_d[ERR_DUP] = 1'b1;
        if (any_we && (state_q == ST_PENDING)) err_d[ERR_PEND] = 1'b1;
        if (bus.coeff_areset) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Flags come straight from the state register, so the update pulse lines
    // up with the edge on which the active words change.
    assign bus.loaded          = (state_q == ST_PENDING);
    assign bus.coeff_update    = (state_q == ST_COMMIT);
    assign bus.out_err         = {{(ERR_W-3){1'b0}}, err_q};
    assign bus.coeff_out_valid = rd_valid;
    assign bus.coeff_out_data  = rd_data;
    assign bus.coeff_active    = active;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_fir_coeff_bank.sv
// Directed plus randomized check of fir_coeff_bank against a word-level
// model of the shadow/active banks, error flags and swap sequencing.
module tb_fir_coeff_bank;
    import fir_coeff_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    fir_coeff_bank_if bus ();

    fir_coeff_bank dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- model and scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          loaded_cnt = 0;
    int          update_cnt = 0;
    logic [7:0]  m_shadow [16];
    logic [7:0]  m_active [16];
    logic        m_written [16];
    logic [2:0]  m_err;
    logic [1:0]  m_phase;
    logic [7:0]  vals [16];
    logic [63:0] exp_q [$];
    int          due_q [$];

    function automatic logic [15:0] sx(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    function automatic logic [127:0] ramp_active();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'(i + 1);
        return r;
    endfunction

    function automatic logic [127:0] pack_vals();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = vals[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_shadow[i]  = 8'h00;
            m_active[i]  = 8'h00;
            m_written[i] = 1'b0;
        end
        m_err   = 3'b000;
        m_phase = ST_IDLE;
        exp_q.delete();
        due_q.delete();
    endtask

    task automatic check_outputs();
        logic [127:0] act;
        logic [63:0]  rd_exp;
        logic [3:0]   v_exp;
        for (int i = 0; i < 16; i++) act[8*i +: 8] = m_active[i];
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            rd_exp = exp_q.pop_front();
            v_exp  = 4'hF;
        end else begin
            rd_exp = '0;
            v_exp  = 4'h0;
        end
        chk("rd_valid", 128'(bus.coeff_out_valid), 128'(v_exp));
        chk("rd_data", 128'(bus.coeff_out_data), 128'(rd_exp));
        chk("active", bus.coeff_active, act);
        chk("loaded", 128'(bus.loaded), 128'(m_phase == ST_PENDING));
        chk("update", 128'(bus.coeff_update), 128'(m_phase == ST_COMMIT));
        chk("out_err", 128'(bus.out_err), 128'({5'b00000, m_err}));
        chk("state", 128'(dbg_state), 128'(m_phase));
        if (bus.loaded === 1'b1) loaded_cnt++;
        if (bus.coeff_update === 1'b1) update_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.coeff_we      = '0;
        bus.coeff_adr     = '0;
        bus.coeff_in_data = '0;
        bus.coeff_read    = 1'b0;
        bus.coeff_areset  = 1'b0;
        bus.swap_ok       = 1'b0;
    endtask

    task automatic cycle(input logic [3:0] we, input logic [1:0] adr, input logic [63:0] din,
                         input logic rd, input logic ar, input logic sw);
        logic [63:0] rword;
        logic [15:0] w;
        logic [1:0]  nxt;
        logic        all_w;
        int          idx;
        bus.coeff_we      = we;
        bus.coeff_adr     = adr;
        bus.coeff_in_data = din;
        bus.coeff_read    = rd;
        bus.coeff_areset  = ar;
        bus.swap_ok       = sw;
        if (rd) begin
            for (int k = 0; k < 4; k++) rword[16*k +: 16] = sx(m_shadow[4*k + int'(adr)]);
            exp_q.push_back(rword);
            due_q.push_back(cyc + 2);
        end
        if (m_phase == ST_PENDING && we == 4'h0 && sw && !ar) begin
            for (int i = 0; i < 16; i++) m_active[i] = m_shadow[i];
        end
        if (ar) begin
            for (int i = 0; i < 16; i++) begin
                m_shadow[i]  = 8'h00;
                m_written[i] = 1'b0;
            end
            m_err = 3'b000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (we[k]) begin
                    idx = 4*k + int'(adr);
                    w   = din[16*k +: 16];
                    if (w != sx(w[7:0])) m_err[0] = 1'b1;
                    if (m_written[idx]) m_err[1] = 1'b1;
                    if (m_phase == ST_PENDING) m_err[2] = 1'b1;
                    m_shadow[idx]  = w[7:0];
                    m_written[idx] = 1'b1;
                end
            end
        end
        all_w = 1'b1;
        for (int i = 0; i < 16; i++) if (!m_written[i]) all_w = 1'b0;
        nxt = m_phase;
        if (ar) begin
            nxt = ST_IDLE;
        end else begin
            case (m_phase)
                ST_IDLE:    if (we != 4'h0) nxt = ST_LOADING;
                ST_LOADING: if (all_w) nxt = ST_PENDING;
                ST_PENDING: begin
                    if (we != 4'h0) nxt = ST_LOADING;
                    else if (sw) nxt = ST_COMMIT;
                end
                default:    nxt = ST_IDLE;
            endcase
        end
        m_phase = nxt;
        tick();
        drive_idle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic write1(input int idx, input logic [15:0] w, input logic sw);
        cycle(4'(1 << (idx / 4)), 2'(idx % 4), 64'(w) << (16 * (idx / 4)), 1'b0, 1'b0, sw);
    endtask

    task automatic apply_reset();
        drive_idle();
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 128'(bus.coeff_out_valid), 128'(0));
        chk("rst_data", 128'(bus.coeff_out_data), 128'(0));
        chk("rst_active", bus.coeff_active, 128'(0));
        chk("rst_loaded", 128'(bus.loaded), 128'(0));
        chk("rst_update", 128'(bus.coeff_update), 128'(0));
        chk("rst_err", 128'(bus.out_err), 128'(0));
        chk("rst_state", 128'(dbg_state), 128'(ST_IDLE));
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset_n = 1'b1;
        drive_idle();
        model_clear();
        #2;
        apply_reset();
        idle(2);

        // Full load of 1..16, then one swap cycle
        loaded_cnt = 0;
        update_cnt = 0;
        for (int i = 0; i < 16; i++) write1(i, 16'(i + 1), 1'b0);
        cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("commit_update", 128'(bus.coeff_update), 128'(1));
        chk("commit_active", bus.coeff_active, ramp_active());
        idle(2);
        chk("loaded_once", 128'(loaded_cnt), 128'(1));
        chk("update_once", 128'(update_cnt), 128'(1));

        // Readback of address 2
        cycle(4'h0, 2'd2, 64'h0, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("rb_valid", 128'(bus.coeff_out_valid), 128'(4'hF));
        chk("rb_data", 128'(bus.coeff_out_data), 128'({16'd15, 16'd11, 16'd7, 16'd3}));

        // Held swap: complete load waits 50 cycles for swap_ok
        cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            vals[i] = 8'($urandom_range(0, 255));
            write1(i, sx(vals[i]), 1'b0);
        end
        loaded_cnt = 0;
        idle(50);
        chk("held_loaded", 128'(loaded_cnt), 128'(50));
        chk("held_active", bus.coeff_active, ramp_active());
        cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b0, 1'b1);
        chk("held_update", 128'(bus.coeff_update), 128'(1));
        chk("held_commit", bus.coeff_active, pack_vals());
        idle(1);

        // Mid-load abort
        cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) write1(i, 16'($urandom_range(0, 127)), 1'b0);
        write1(0, 16'h0180, 1'b0);
        chk("abort_err_pre", 128'(bus.out_err), 128'(8'h03));
        cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b1, 1'b0);
        chk("abort_state", 128'(dbg_state), 128'(ST_IDLE));
        chk("abort_err", 128'(bus.out_err), 128'(0));
        cycle(4'h0, 2'd0, 64'h0, 1'b1, 1'b0, 1'b0);
        cycle(4'h0, 2'd1, 64'h0, 1'b1, 1'b0, 1'b0);
        chk("abort_rd_valid", 128'(bus.coeff_out_valid), 128'(4'hF));
        chk("abort_rd_data", 128'(bus.coeff_out_data), 128'(0));
        cycle(4'h0, 2'd2, 64'h0, 1'b1, 1'b0, 1'b0);
        cycle(4'h0, 2'd3, 64'h0, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("abort_active", bus.coeff_active, pack_vals());

        // Error flags
        cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b1, 1'b0);
        write1(0, 16'h0180, 1'b0);
        chk("err_range", 128'(bus.out_err), 128'(8'h01));
        write1(4, 16'h0005, 1'b0);
        write1(4, 16'h0006, 1'b0);
        chk("err_dup", 128'(bus.out_err), 128'(8'h03));
        for (int i = 1; i < 16; i++) if (i != 4) write1(i, 16'(i + 1), 1'b0);
        chk("err_pending", 128'(dbg_state), 128'(ST_PENDING));
        write1(9, 16'h0022, 1'b0);
        chk("err_pend_flag", 128'(bus.out_err), 128'(8'h07));
        chk("err_pend_state", 128'(dbg_state), 128'(ST_LOADING));
        cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b0, 1'b1);
        cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Read and write of the same word in one cycle returns the old value
        cycle(4'h8, 2'd3, 64'h007F << 48, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("rbw_data", 128'(bus.coeff_out_data[63:48]), 128'(16'h0010));
        idle(2);

        // Randomized traffic
        cycle(4'h0, 2'd0, 64'h0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 400; n++) begin
            logic [63:0] din;
            logic [3:0]  we;
            for (int k = 0; k < 4; k++)
                din[16*k +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : sx(8'($urandom));
            we = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            cycle(we, 2'($urandom_range(0, 3)), din, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) == 0));
        end
        idle(3);

        // Reset one cycle after a read request
        cycle(4'h0, 2'd1, 64'h0, 1'b1, 1'b0, 1'b0);
        apply_reset();
        idle(3);
        chk("post_rst_valid", 128'(bus.coeff_out_valid), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
